// File: rtl/dbus_arbiter_pkg.sv
// Shared types for the data-bus arbiter: bus request/response structs,
// the arbiter state encoding and the requester count.
package dbus_arbiter_pkg;

    localparam int N_SLOT = 2;

    typedef logic [31:0] addr_t;

    typedef struct packed {
        logic        valid;
        addr_t       addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_DONE  = 3'd5,
        ST_DRAIN = 3'd6
    } arb_state_t;

endpackage

// File: rtl/dbus_arbiter_chk.sv
// Protocol checker for the arbiter: a data_ok beat while no transaction
// can be outstanding (IDLE or DONE) is a bus protocol error.
module dbus_arbiter_chk
    import dbus_arbiter_pkg::*;
(
    input logic       clk,
    input logic       resetn,
    input arb_state_t state,
    input logic       data_ok
);

    a_no_stray_data_ok: assert property (
        @(posedge clk) disable iff (!resetn)
        !(data_ok && ((state == ST_IDLE) || (state == ST_DONE)))
    );

endmodule

// File: rtl/dbus_req_buf.sv
// Single-slot request latch. load captures a new request (valid included);
// kill drops a request that has not been issued yet.
module dbus_req_buf
    import dbus_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    input  logic      load,
    input  logic      kill,
    input  dbus_req_t req_in,
    output dbus_req_t req_out
);

    dbus_req_t req_q;
    dbus_req_t req_d;

    // Next buffer contents: load wins over kill, otherwise hold.
    always_comb begin
        req_d = req_q;
        if (load) begin
            req_d = req_in;
        end else if (kill) begin
            req_d.valid = 1'b0;
        end else begin
            req_d = req_q;
        end
    end

    // Buffer register, cleared on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign req_out = req_q;

endmodule

// File: rtl/dbus_arbiter.sv
// Serialises the two memory-stage requests of the dual-issue pipe onto the
// single dbus port in program order, collects the load data and stalls the
// pipe until the bundle completes. A flush drains whatever is on the bus
// and discards its data.
// Optional: define DBUS_ARB_PERF_EN to add stall-cycle and handshake counters.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  dbus_req_t   dreq0,
    input  dbus_req_t   dreq1,
    input  logic        flush,
    output dbus_req_t   dreq,
    input  dbus_resp_t  dresp,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        stall
`ifdef DBUS_ARB_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_req_cnt
`endif
);

    arb_state_t  state_q, state_d;
    logic        drain_slot_q, drain_slot_d;
    logic        pend_q, pend_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        buf_load_s;
    logic        kill1_s;
    logic        slot_s;
    dbus_req_t   buf0_s, buf1_s, cur_s, dreq_s;
    logic        stall_s;
    arb_state_t  after_s;

    dbus_req_buf u_buf0 (
        .clk     (clk),
        .resetn  (resetn),
        .load    (buf_load_s),
        .kill    (1'b0),
        .req_in  (dreq0),
        .req_out (buf0_s)
    );

    dbus_req_buf u_buf1 (
        .clk     (clk),
        .resetn  (resetn),
        .load    (buf_load_s),
        .kill    (kill1_s),
        .req_in  (dreq1),
        .req_out (buf1_s)
    );

    // Which buffered slot the current state is working on.
    always_comb begin
        slot_s = 1'b0;
        case (state_q)
            ST_REQ1, ST_WAIT1: slot_s = 1'b1;
            ST_DRAIN:          slot_s = drain_slot_q;
            default:           slot_s = 1'b0;
        endcase
        if (slot_s) begin
            cur_s = buf1_s;
        end else begin
            cur_s = buf0_s;
        end
        if (!slot_s && buf1_s.valid) begin
            after_s = ST_REQ1;
        end else begin
            after_s = ST_DONE;
        end
    end

    // Next-state, bus request, stall and data capture.
    always_comb begin
        state_d      = state_q;
        drain_slot_d = drain_slot_q;
        pend_d       = pend_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        buf_load_s   = 1'b0;
        kill1_s      = 1'b0;
        dreq_s       = '0;
        stall_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((dreq0.valid || dreq1.valid) && !flush) begin
                    buf_load_s = 1'b1;
                    stall_s    = 1'b1;
                    state_d    = dreq0.valid ? ST_REQ0 : ST_REQ1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ0, ST_REQ1: begin
                stall_s      = 1'b1;
                dreq_s       = cur_s;
                dreq_s.valid = 1'b1;
                if (flush) begin
                    // The driven request cannot be withdrawn; drain it.
                    kill1_s      = !slot_s;
                    drain_slot_d = slot_s;
                    if (dresp.addr_ok && dresp.data_ok) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                        pend_d  = !dresp.addr_ok;
                    end
                end else if (dresp.addr_ok && dresp.data_ok) begin
                    if (slot_s) rdata1_d = dresp.data;
                    else        rdata0_d = dresp.data;
                    state_d = after_s;
                end else if (dresp.addr_ok) begin
                    state_d = slot_s ? ST_WAIT1 : ST_WAIT0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT0, ST_WAIT1: begin
                stall_s = 1'b1;
                if (flush) begin
                    kill1_s      = !slot_s;
                    drain_slot_d = slot_s;
                    pend_d       = 1'b0;
                    state_d      = dresp.data_ok ? ST_IDLE : ST_DRAIN;
                end else if (dresp.data_ok) begin
                    if (slot_s) rdata1_d = dresp.data;
                    else        rdata0_d = dresp.data;
                    state_d = after_s;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRAIN: begin
                stall_s = 1'b1;
                if (pend_q) begin
                    dreq_s       = cur_s;
                    dreq_s.valid = 1'b1;
                    if (dresp.addr_ok) begin
                        pend_d  = 1'b0;
                        state_d = dresp.data_ok ? ST_IDLE : ST_DRAIN;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (dresp.data_ok) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and load-data registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            drain_slot_q <= 1'b0;
            pend_q       <= 1'b0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            drain_slot_q <= drain_slot_d;
            pend_q       <= pend_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign dreq   = dreq_s;
    assign stall  = stall_s;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

    dbus_arbiter_chk u_chk (
        .clk     (clk),
        .resetn  (resetn),
        .state   (state_q),
        .data_ok (dresp.data_ok)
    );

`ifdef DBUS_ARB_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_req_q, perf_req_d;

    // Wrap-around counters of stall cycles and addr_ok handshakes.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_req_d   = perf_req_q;
        if (stall_s) perf_stall_d = perf_stall_q + 32'd1;
        else         perf_stall_d = perf_stall_q;
        if (dreq_s.valid && dresp.addr_ok) perf_req_d = perf_req_q + 32'd1;
        else                               perf_req_d = perf_req_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_q <= 32'd0;
            perf_req_q   <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_req_q   <= perf_req_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_req_cnt   = perf_req_q;
`endif

endmodule
